// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family.
//   FIFO_DATA_W / FIFO_DEPTH : default word width and entry count
//   clog2()                  : ceiling log2, usable in constant expressions
//   fifo_cnt_w()             : width of count/level ports, enough to hold 0..depth
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // One bit more than the address so a completely full FIFO (== depth) fits.
  function automatic int fifo_cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// DEPTH x DATA_W storage for the FIFO.
//   clk   : write clock
//   we    : write enable, wdata stored at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : word at raddr, combinational
// Contents are deliberately not reset.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parameterised single-clock FIFO with registered or first-word-fall-through
// read, programmable almost-full/almost-empty levels, fill count and sticky,
// clearable overflow/underflow flags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr, data_in         : write request and data
//   rd                  : read request
//   err_clr             : clears sticky overflow/underflow (a new set wins)
//   af_level, ae_level  : almost-full / almost-empty levels (live compare)
//   data_out            : read data (registered on accepted read, or head word in FWFT)
//   fifo_count          : occupancy 0..DEPTH
//   fifo_full/empty     : occupancy status from the pointers
//   fifo_almost_full    : count >= af_level
//   fifo_almost_empty   : count <= ae_level
//   fifo_overflow       : sticky, write attempted while full
//   fifo_underflow      : sticky, read attempted while empty
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int FWFT   = 0,
  localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  input  logic              err_clr,
  input  logic [CNT_W-1:0]  af_level,
  input  logic [CNT_W-1:0]  ae_level,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Pointers carry an extra wrap bit above the memory address.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] head_word;

  // ---- status from registered state ----
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_acc = wr & ~fifo_full;
  assign rd_acc = rd & ~fifo_empty;

  assign fifo_count        = count_q;
  assign fifo_almost_full  = (count_q >= af_level);
  assign fifo_almost_empty = (count_q <= ae_level);
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = unf_q;

  // ---- next state ----
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
    else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
    // A rejected request in the same cycle as err_clr keeps the flag set.
    ovf_d = (wr & fifo_full)  | (ovf_q & ~err_clr);
    unf_d = (rd & fifo_empty) | (unf_q & ~err_clr);
  end

  // ---- state registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (head_word)
  );

  // ---- read data path ----
  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible as soon as it is stored; zero while empty.
      assign data_out = fifo_empty ? '0 : head_word;
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dout_q <= '0;
        else if (rd_acc) dout_q <= head_word;
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  logic       clk;
  logic       rst_n;
  logic       wr_a, rd_a, clr_a;
  logic [7:0] din_a;
  logic       wr_b, rd_b, clr_b;
  logic [7:0] din_b;
  logic [4:0] af_lvl, ae_lvl;

  logic [7:0] dout_a, dout_b;
  logic [4:0] cnt_a, cnt_b;
  logic full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic full_b, empty_b, af_b, ae_b, ovf_b, unf_b;

  int n_cmp = 0;
  int n_err = 0;

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr(wr_a), .rd(rd_a), .data_in(din_a),
    .err_clr(clr_a), .af_level(af_lvl), .ae_level(ae_lvl),
    .data_out(dout_a), .fifo_count(cnt_a), .fifo_full(full_a),
    .fifo_empty(empty_a), .fifo_almost_full(af_a), .fifo_almost_empty(ae_a),
    .fifo_overflow(ovf_a), .fifo_underflow(unf_a)
  );

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr(wr_b), .rd(rd_b), .data_in(din_b),
    .err_clr(clr_b), .af_level(af_lvl), .ae_level(ae_lvl),
    .data_out(dout_b), .fifo_count(cnt_b), .fifo_full(full_b),
    .fifo_empty(empty_b), .fifo_almost_full(af_b), .fifo_almost_empty(ae_b),
    .fifo_overflow(ovf_b), .fifo_underflow(unf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock on DUT A, inputs released afterwards; sampled 1 time unit after the edge.
  task automatic cyc_a(input logic w, input logic r, input logic [7:0] d, input logic c);
    wr_a = w; rd_a = r; din_a = d; clr_a = c;
    @(posedge clk); #1;
    wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic cyc_b(input logic w, input logic r, input logic [7:0] d);
    wr_b = w; rd_b = r; din_b = d;
    @(posedge clk); #1;
    wr_b = 1'b0; rd_b = 1'b0;
  endtask

  initial begin
    wr_a = 0; rd_a = 0; clr_a = 0; din_a = 0;
    wr_b = 0; rd_b = 0; clr_b = 0; din_b = 0;
    af_lvl = 5'd12; ae_lvl = 5'd3;
    rst_n = 1'b1;

    // 1. reset with no clock edge yet (first posedge at t=5)
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_empty", empty_a, 1'b1);
    chk1("rst_full", full_a, 1'b0);
    chk8("rst_count", 8'(cnt_a), 8'd0);
    chk8("rst_dout", dout_a, 8'h00);
    chk1("rst_ovf", ovf_a, 1'b0);
    chk1("rst_unf", unf_a, 1'b0);
    chk1("rst_ae", ae_a, 1'b1);
    chk1("rst_af", af_a, 1'b0);
    chk8("rst_b_dout", dout_b, 8'h00);
    chk1("rst_b_flags", af_b | ovf_b | unf_b | full_b, 1'b0);
    chk1("rst_b_ae", ae_b, 1'b1);
    #5 rst_n = 1'b1;   // t=7, between edges
    @(posedge clk); #1;

    // 2./3. fill with 0x01..0x10, thresholds on the way up
    for (int i = 1; i <= 16; i++) begin
      cyc_a(1'b1, 1'b0, 8'(i), 1'b0);
      chk8("fill_count", 8'(cnt_a), 8'(i));
      chk1("fill_af", af_a, i >= 12);
      chk1("fill_ae", ae_a, i <= 3);
    end
    chk1("fill_full", full_a, 1'b1);
    cyc_a(1'b1, 1'b0, 8'h11, 1'b0);
    chk1("ovf_set", ovf_a, 1'b1);
    chk8("ovf_count", 8'(cnt_a), 8'd16);

    // drain, data valid one cycle after rd
    for (int i = 1; i <= 16; i++) begin
      cyc_a(1'b0, 1'b1, 8'h00, 1'b0);
      chk8("drain_data", dout_a, 8'(i));
      chk8("drain_count", 8'(cnt_a), 8'(16 - i));
      chk1("drain_ae", ae_a, (16 - i) <= 3);
    end
    chk1("drain_empty", empty_a, 1'b1);
    cyc_a(1'b0, 1'b1, 8'h00, 1'b0);
    chk1("unf_set", unf_a, 1'b1);
    chk8("unf_hold", dout_a, 8'h10);
    cyc_a(1'b0, 1'b0, 8'h00, 1'b1);
    chk1("clr_ovf", ovf_a, 1'b0);
    chk1("clr_unf", unf_a, 1'b0);

    // 4. wrap and steady state
    for (int i = 0; i < 10; i++) cyc_a(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc_a(1'b0, 1'b1, 8'h00, 1'b0);
      chk8("wrap_rd", dout_a, 8'(8'h20 + i));
    end
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    chk8("ss_start_count", 8'(cnt_a), 8'd5);
    for (int k = 0; k < 20; k++) begin
      cyc_a(1'b1, 1'b1, 8'(8'h50 + k), 1'b0);
      chk8("ss_count", 8'(cnt_a), 8'd5);
      chk8("ss_data", dout_a, (k < 5) ? 8'(8'h40 + k) : 8'(8'h50 + k - 5));
    end
    // queue now holds 0x5F..0x63

    // 5. boundary simultaneity
    for (int i = 0; i < 11; i++) cyc_a(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
    chk1("b5_full", full_a, 1'b1);
    cyc_a(1'b1, 1'b1, 8'hEE, 1'b0);
    chk8("b5_full_rw_count", 8'(cnt_a), 8'd15);
    chk1("b5_full_rw_ovf", ovf_a, 1'b1);
    chk8("b5_full_rw_head", dout_a, 8'h5F);
    cyc_a(1'b0, 1'b0, 8'h00, 1'b1);
    chk1("b5_clr_ovf", ovf_a, 1'b0);
    chk1("b5_clr_unf", unf_a, 1'b0);
    cyc_a(1'b1, 1'b0, 8'h7B, 1'b0);
    chk8("b5_refill", 8'(cnt_a), 8'd16);
    cyc_a(1'b1, 1'b0, 8'hCC, 1'b1);
    chk1("b5_set_wins", ovf_a, 1'b1);
    chk8("b5_set_wins_count", 8'(cnt_a), 8'd16);
    cyc_a(1'b0, 1'b0, 8'h00, 1'b1);
    chk1("b5_clr2", ovf_a, 1'b0);
    for (int i = 0; i < 16; i++) cyc_a(1'b0, 1'b1, 8'h00, 1'b0);
    chk8("b5_last_word", dout_a, 8'h7B);
    chk1("b5_empty", empty_a, 1'b1);
    cyc_a(1'b1, 1'b1, 8'h99, 1'b0);
    chk8("b5_empty_rw_count", 8'(cnt_a), 8'd1);
    chk1("b5_empty_rw_unf", unf_a, 1'b1);
    chk8("b5_empty_rw_hold", dout_a, 8'h7B);
    cyc_a(1'b0, 1'b1, 8'h00, 1'b1);
    chk8("b5_read_99", dout_a, 8'h99);
    chk1("b5_unf_clr", unf_a, 1'b0);

    // 6. FWFT instance
    cyc_b(1'b1, 1'b0, 8'hA5);
    chk8("fwft_head", dout_b, 8'hA5);
    chk1("fwft_not_empty", empty_b, 1'b0);
    cyc_b(1'b0, 1'b1, 8'h00);
    chk8("fwft_empty_dout", dout_b, 8'h00);
    chk1("fwft_empty", empty_b, 1'b1);
    cyc_b(1'b1, 1'b0, 8'h11);
    cyc_b(1'b1, 1'b0, 8'h22);
    chk8("fwft_head2", dout_b, 8'h11);
    cyc_b(1'b0, 1'b1, 8'h00);
    chk8("fwft_advance", dout_b, 8'h22);
    chk8("fwft_count", 8'(cnt_b), 8'd1);

    // mid-operation asynchronous reset at count 7
    for (int i = 0; i < 7; i++) cyc_a(1'b1, 1'b0, 8'(8'hB0 + i), 1'b0);
    chk8("pre_rst_count", 8'(cnt_a), 8'd7);
    #1 rst_n = 1'b0;
    #1;
    chk8("arst_count", 8'(cnt_a), 8'd0);
    chk1("arst_empty", empty_a, 1'b1);
    chk8("arst_dout", dout_a, 8'h00);
    chk8("arst_b_count", 8'(cnt_b), 8'd0);
    #1 rst_n = 1'b1;
    cyc_a(1'b1, 1'b0, 8'h33, 1'b0);
    cyc_a(1'b0, 1'b1, 8'h00, 1'b0);
    chk8("post_rst_data", dout_a, 8'h33);
    chk1("post_rst_empty", empty_a, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
